// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: datapath width, writeback source encodings, rd field position.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam int RD_MSB = 11;
    localparam int RD_LSB = 7;

    localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register array: one synchronous write port, two raw asynchronous reads.
module regfile_2r1w
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Reset clears the whole array so reads of any register return 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB consumer: selects the writeback value, commits it to the register file,
// serves decode reads with write-through bypass and keeps cycle/instret counters.
module writeback_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             reg_write_in,
    input  logic [1:0]       mem_reg_in,
    input  logic [XLEN-1:0]  alu_res_in,
    input  logic [XLEN-1:0]  wrap_load_in,
    input  logic [XLEN-1:0]  next_sel_address_in,
    input  logic [31:0]      instruction_in,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             wb_en_out,
    output logic [4:0]       wb_rd_out,
    output logic [XLEN-1:0]  wb_data_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    logic [XLEN-1:0]  rf_rdata1;
    logic [XLEN-1:0]  rf_rdata2;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    // Only the rd field of the instruction word matters at writeback.
    logic unused_instr;
    assign unused_instr = &{1'b0, instruction_in[31:RD_MSB+1], instruction_in[RD_LSB-1:0]};

    function automatic logic [XLEN-1:0] read_port(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] raw,
        input logic            byp_en,
        input logic [4:0]      byp_rd,
        input logic [XLEN-1:0] byp_data
    );
        if (addr == 5'd0)
            return '0;
        else if (byp_en && (addr == byp_rd))
            return byp_data;
        else
            return raw;
    endfunction

    always_comb begin
        wb_data_out = alu_res_in;
        unique case (mem_reg_in)
            WB_SEL_ALU:  wb_data_out = alu_res_in;
            WB_SEL_LOAD: wb_data_out = wrap_load_in;
            WB_SEL_PC4:  wb_data_out = next_sel_address_in;
            default:     wb_data_out = alu_res_in;
        endcase
    end

    assign wb_rd_out = instruction_in[RD_MSB:RD_LSB];
    assign wb_en_out = valid_in & reg_write_in & (wb_rd_out != 5'd0) & ~rst;

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (5)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en_out),
        .waddr  (wb_rd_out),
        .wdata  (wb_data_out),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    assign rs1_data = read_port(rs1_addr, rf_rdata1, wb_en_out, wb_rd_out, wb_data_out);
    assign rs2_data = read_port(rs2_addr, rf_rdata2, wb_en_out, wb_rd_out, wb_data_out);

    // Counters wrap freely; an instruction present during reset is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (valid_in)
                instret_q <= instret_q + 1'b1;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Consumer end of the MEM/WB pipeline register: takes the registered MEM/WB bundle, selects the writeback value and commits it to the architectural register file.
- Serves the decode stage's two combinational register reads, with write-through bypass of the value being committed this cycle.
- Exports the committed write (data/rd/enable) for EX forwarding.
- Maintains 64-bit cycle and retired-instruction counters.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural registers; index width is log2(NREGS).
- CNT_W, 64, counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  MEM/WB slot holds a real instruction (0 = bubble)
- reg_write_in  in  1  instruction writes rd
- mem_reg_in  in  2  writeback source select
- alu_res_in  in  XLEN  ALU result
- wrap_load_in  in  XLEN  aligned/extended load data
- next_sel_address_in  in  XLEN  PC+4 link value
- instruction_in  in  32  instruction word; rd = [11:7]
- rs1_addr  in  5  read port 1 address
- rs2_addr  in  5  read port 2 address
- rs1_data  out  XLEN  read port 1 data, combinational
- rs2_data  out  XLEN  read port 2 data, combinational
- wb_en_out  out  1  commit happening this cycle
- wb_rd_out  out  5  commit destination
- wb_data_out  out  XLEN  commit value
- cycle_count  out  CNT_W  cycles since reset
- instret_count  out  CNT_W  retired instructions since reset

Behaviour:
- One clock, clk; reset rst is synchronous and active-high. All state changes occur on posedge clk.
- Writeback source select, mem_reg_in:
  - 00 selects alu_res_in.
  - 01 selects wrap_load_in.
  - 10 selects next_sel_address_in.
  - 11 is reserved and selects alu_res_in.
- wb_data_out is the selected value, combinational.
- wb_rd_out = instruction_in[11:7], combinational.
- wb_en_out = valid_in & reg_write_in & (rd != 0) & !rst.
- Register write: on the clk edge with wb_en_out=1, reg[rd] <= wb_data_out. Latency is 1 edge to the array, but the value is visible at the read ports in the same cycle via bypass.
- Read path, per port, combinational, in priority order:
  1. addr==0 returns 0.
  2. Otherwise, if wb_en_out=1 and addr==wb_rd_out, return wb_data_out (write-through bypass).
  3. Otherwise return reg[addr].
- x0 is never written. rd=0 with reg_write_in=1 gives no write, no bypass and wb_en_out=0.
- Both ports may read the same address; both may hit the bypass simultaneously.
- Counters:
  - cycle_count increments by 1 every cycle rst=0.
  - instret_count increments when valid_in=1 and rst=0, regardless of reg_write_in.
  - Both wrap modulo 2^CNT_W, with no saturation and no flag.
- Reset: rst=1 at an edge has priority over everything.
  - All NREGS registers clear to 0.
  - cycle_count and instret_count clear to 0.
  - No write occurs.
- While rst=1, wb_en_out=0 and the bypass is disabled. Read ports return array contents; after the first reset edge these are all 0.
- Reset mid-stream: an in-flight MEM/WB instruction present during the reset cycle is discarded, neither written nor counted.
- Output values after the reset edge:
  - cycle_count=0, instret_count=0.
  - rs*_data=0 unless a bypass hits.
  - wb_* reflect the inputs, gated as above.
- Bubbles (valid_in=0) perform no write and no count. Side-band inputs are don't-care.

Decomposition:
- Shared package (rv32i_pkg):
  - XLEN.
  - WB_SEL_ALU=2'b00, WB_SEL_LOAD=2'b01, WB_SEL_PC4=2'b10.
  - RD_MSB=11, RD_LSB=7.
  - NOP=32'h00000013.
- Sub-module regfile_2r1w: the NREGS x XLEN array with sync reset, one write port and two raw async reads.
- Source mux, bypass, x0 masking and counters stay in writeback_stage.

Test Plan:
- Reset then idle 5 cycles with valid_in=0 -> cycle_count=5, instret_count=0, rs1_data=rs2_data=0 for all addresses.
- valid=1, reg_write=1, mem_reg=00, alu_res=0xDEADBEEF, instruction rd=5, rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF via bypass, wb_en_out=1. Next cycle with valid=0 -> rs1_data=0xDEADBEEF from array; instret=1.
- mem_reg=01 with wrap_load=0xFFFFFF80, rd=7; then mem_reg=10 with next_sel_address=0x00000104, rd=1 -> x7=0xFFFFFF80, x1=0x104. mem_reg=11 writes alu_res.
- rd=0, reg_write=1, alu_res=0x1234 -> wb_en_out=0, rs1_addr=0 gives 0, instret increments. valid=0 with reg_write=1 and rd=3 -> x3 unchanged.
- Write x9=0xAAAA5555, then a cycle with rst=1 and a valid write to x9=0x1 -> after the edge x9=0, both counters=0, wb_en_out=0 during rst.
- Force cycle_count to 2^64-1 via backdoor -> next cycle reads 0; same check for instret_count.
